// File: rtl/data_memory_lat_pkg.sv
// data_memory_lat_pkg: shared types, constants and byte-merge helper for data_memory_lat.
package data_memory_lat_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int LATENCY_MIN = 1;
    localparam int LINE_MAX_W = 2048;
    // Lines narrower than LINE_MAX_W are zero-extended by the caller and truncated on return.
    function automatic logic [LINE_MAX_W-1:0] byte_merge(
        input logic [LINE_MAX_W-1:0]   old_line,
        input logic [LINE_MAX_W-1:0]   new_line,
        input logic [LINE_MAX_W/8-1:0] strb
    );
        logic [LINE_MAX_W-1:0] line;
        line = old_line;
        for (int b = 0; b < LINE_MAX_W / 8; b++)
            if (strb[b]) line[b*8 +: 8] = new_line[b*8 +: 8];
        return line;
    endfunction
endpackage

// File: rtl/dm_line_ram.sv
// dm_line_ram: DEPTH x DATA_W line array with synchronous write and combinational read.
module dm_line_ram #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] memory [DEPTH];
    always_ff @(posedge clk)
        if (we) memory[idx] <= wdata;
    assign rdata = memory[idx];
endmodule

// File: rtl/data_memory_lat.sv
// data_memory_lat: fixed-latency line-wide backing memory with enable/ack handshake.
// Define DATA_MEMORY_LAT_STRB_EN to add strb_i and byte-strobed writes.
module data_memory_lat
    import data_memory_lat_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                enable_i,
    input  logic                write_i,
`ifdef DATA_MEMORY_LAT_STRB_EN
    input  logic [DATA_W/8-1:0] strb_i,
`endif
    output logic                ack_o,
    output logic [DATA_W-1:0]   data_o,
    output logic                busy_o,
    output logic                err_o
);
    localparam int OB = $clog2(DATA_W / 8);
    localparam int IW = $clog2(DEPTH);
    localparam int HW = ADDR_W - OB;
    localparam int CW = (LATENCY > LATENCY_MIN) ? $clog2(LATENCY) : 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [HW-1:0]     line_q;
    logic [DATA_W-1:0] data_q;
    logic              write_q;
    logic [IW-1:0]     idx;
    logic              oor;
    logic              we;
    logic [DATA_W-1:0] rd_line;
    logic [DATA_W-1:0] new_line;
    logic              unused_addr;

    assign unused_addr = ^addr_i[OB-1:0];
    assign idx = line_q[IW-1:0];
    assign oor = |(line_q >> IW);
    // Reset on the DONE edge must abort the write as well as the ack.
    assign we  = state == DONE && write_q && !oor && !rst_i;

`ifdef DATA_MEMORY_LAT_STRB_EN
    logic [DATA_W/8-1:0] strb_q;
    assign new_line = write_q
        ? DATA_W'(byte_merge(LINE_MAX_W'(rd_line), LINE_MAX_W'(data_q), (LINE_MAX_W/8)'(strb_q)))
        : rd_line;
`else
    assign new_line = write_q ? data_q : rd_line;
`endif

    dm_line_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk_i),
        .we    (we),
        .idx   (idx),
        .wdata (new_line),
        .rdata (rd_line)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            line_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
`ifdef DATA_MEMORY_LAT_STRB_EN
            strb_q  <= '0;
`endif
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            data_o  <= '0;
        end else begin
            ack_o <= state == DONE;
            err_o <= state == DONE && oor;
            case (state)
                IDLE: begin
                    busy_o <= enable_i;
                    if (enable_i) begin
                        line_q  <= addr_i[ADDR_W-1:OB];
                        data_q  <= data_i;
                        write_q <= write_i;
`ifdef DATA_MEMORY_LAT_STRB_EN
                        strb_q  <= strb_i;
`endif
                        cnt     <= CW'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    data_o <= oor ? '0 : new_line;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_lat.sv
// tb_data_memory_lat: directed and randomized checks of data_memory_lat against a line-array model.
module tb_data_memory_lat;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, en1, wr;
    logic [31:0]  addr;
    logic [255:0] din;
`ifdef DATA_MEMORY_LAT_STRB_EN
    logic [31:0]  strb;
`endif
    logic         ack, busy, err, ack1, busy1, err1;
    logic [255:0] dout, dout1;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] mdl [512];

    data_memory_lat dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(din), .enable_i(en), .write_i(wr),
`ifdef DATA_MEMORY_LAT_STRB_EN
        .strb_i(strb),
`endif
        .ack_o(ack), .data_o(dout), .busy_o(busy), .err_o(err)
    );

    data_memory_lat #(.LATENCY(1)) d1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(din), .enable_i(en1), .write_i(wr),
`ifdef DATA_MEMORY_LAT_STRB_EN
        .strb_i(strb),
`endif
        .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .err_o(err1)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old_line, input logic [255:0] nw, input logic [31:0] s);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[b*8 +: 8] = s[b] ? nw[b*8 +: 8] : old_line[b*8 +: 8];
        return r;
    endfunction

    // One request on the LATENCY=10 instance; returns cycles from accept edge to ack.
    task automatic req(input logic [31:0] a, input logic [255:0] d, input logic w, input logic [31:0] s,
                       output int lat, output logic [255:0] q, output logic e);
        @(negedge clk);
        addr = a; din = d; wr = w; en = 1'b1;
`ifdef DATA_MEMORY_LAT_STRB_EN
        strb = s;
`else
        if (s != 32'hFFFF_FFFF) $display("note: strobes ignored in full-line build");
`endif
        @(negedge clk);
        en = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < 40) begin
            check("busy_wait", busy, 1);
            @(negedge clk);
            lat++;
        end
        check("busy_ack", busy, 1);
        q = dout;
        e = err;
        @(negedge clk);
        check("ack_pulse", ack, 0);
        check("err_idle", err, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int           lat;
        logic [255:0] q, old0;
        logic         e;
        rst = 1'b1; en = 1'b0; en1 = 1'b0; wr = 1'b0; addr = '0; din = '0;
`ifdef DATA_MEMORY_LAT_STRB_EN
        strb = '1;
`endif
        for (int i = 0; i < 512; i++) begin
            mdl[i] = rnd256();
            dut.u_ram.memory[i] = mdl[i];
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_data", dout, 0);

        // Read of preloaded line 0
        mdl[0] = 256'h5;
        dut.u_ram.memory[0] = 256'h5;
        req(32'h0, 256'h0, 1'b0, '1, lat, q, e);
        check("rd0_lat", 256'(lat), 10);
        check("rd0_data", q, 256'h5);
        check("rd0_err", e, 0);

        // Write then read line 2 with enable held across the first ack
        @(negedge clk);
        addr = 32'h40; din = 256'hDEAD_BEEF; wr = 1'b1; en = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        for (int n = 0; n < 25; n++) begin
            if (n == 11) en = 1'b0;
            check("hold_ack", ack, 256'(n == 10 || n == 21));
            if (n == 10 || n == 21) check("hold_data", dout, 256'hDEAD_BEEF);
            @(negedge clk);
        end
        mdl[2] = 256'hDEAD_BEEF;
        check("wr_mem2", dut.u_ram.memory[2], mdl[2]);

        // Out-of-range read and write (write would alias line 2)
        req(32'h0001_0000, 256'h0, 1'b0, '1, lat, q, e);
        check("oor_rd_lat", 256'(lat), 10);
        check("oor_rd_err", e, 1);
        check("oor_rd_data", q, 0);
        req(32'h0001_0040, 256'h1234, 1'b1, '1, lat, q, e);
        check("oor_wr_err", e, 1);
        check("oor_wr_data", q, 0);
        check("oor_wr_mem2", dut.u_ram.memory[2], mdl[2]);

        // LATENCY=1 instance with enable held: ack every second cycle
        d1.u_ram.memory[0] = 256'h77;
        @(negedge clk);
        addr = 32'h0; wr = 1'b0; en1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            check("l1_ack", ack1, 256'(k % 2));
            check("l1_busy", busy1, 1);
            if (k % 2 == 1) begin
                check("l1_data", dout1, 256'h77);
                check("l1_err", err1, 0);
            end
            @(negedge clk);
        end
        en1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset five cycles into a write of line 0
        old0 = mdl[0];
        @(negedge clk);
        addr = 32'h0; din = rnd256(); wr = 1'b1; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ack", ack, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", dout, 0);
        for (int n = 0; n < 12; n++) begin
            check("mid_rst_no_ack", ack, 0);
            @(negedge clk);
        end
        check("mid_rst_mem0", dut.u_ram.memory[0], old0);

`ifdef DATA_MEMORY_LAT_STRB_EN
        mdl[1] = '1;
        dut.u_ram.memory[1] = '1;
        req(32'h20, 256'h0, 1'b1, 32'h0000_000F, lat, q, e);
        check("strb_data", q, {{224{1'b1}}, 32'h0});
        mdl[1] = {{224{1'b1}}, 32'h0};
        req(32'h20, rnd256(), 1'b1, 32'h0, lat, q, e);
        check("strb_none_data", q, mdl[1]);
        check("strb_none_mem", dut.u_ram.memory[1], mdl[1]);
`endif

        // Randomized traffic against the line model
        for (int i = 0; i < 30; i++) begin
            int           line;
            logic         oor, w;
            logic [31:0]  a, s;
            logic [255:0] d, exp;
            line = int'($urandom_range(0, 511));
            oor = ($urandom_range(0, 4) == 0);
            a = (32'(line) << 5) | ($urandom & 32'h1F);
            if (oor) a = a | (32'h1 << $urandom_range(14, 31));
            w = 1'($urandom);
            d = rnd256();
`ifdef DATA_MEMORY_LAT_STRB_EN
            s = $urandom;
`else
            s = '1;
`endif
            req(a, d, w, s, lat, q, e);
            if (oor) exp = '0;
            else begin
                if (w) mdl[line] = merge(mdl[line], d, s);
                exp = mdl[line];
            end
            check("rnd_lat", 256'(lat), 10);
            check("rnd_data", q, exp);
            check("rnd_err", e, 256'(oor));
            check("rnd_mem", dut.u_ram.memory[line], mdl[line]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_lat.md
# data_memory_lat

Parametrised, fixed-latency, line-wide data memory. It sits behind the data cache as the backing store. It accepts one read or write request at a time through an enable/ack handshake and returns an acknowledge a configurable number of cycles later. It generalises the fixed 256-bit, fixed-delay data memory with configurable line width, depth and latency, explicit busy and error reporting, and optional byte-strobed writes.

## Interface
- DATA_W, 256, line width in bits; a multiple of 8, minimum 32
- ADDR_W, 32, byte address width
- DEPTH, 512, number of lines; a power of two
- LATENCY, 10, cycles from request accept to ack; minimum 1
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- addr_i  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
- data_i  in  DATA_W  write line
- enable_i  in  1  request valid
- write_i  in  1  1 = write, 0 = read
- strb_i  in  DATA_W/8  byte write strobes; present only with DATA_MEMORY_LAT_STRB_EN
- ack_o  out  1  one-cycle completion pulse
- data_o  out  DATA_W  read data, or the resulting line after a write
- busy_o  out  1  request in flight; new requests ignored
- err_o  out  1  valid with ack_o; address out of range

## Operation
- States: IDLE, WAIT, DONE.
- IDLE with enable_i=1:
  - capture addr, data, write and strobes;
  - load the counter with LATENCY-1;
  - go to WAIT, or straight to DONE when LATENCY=1.
- WAIT: decrement the counter; go to DONE when it reaches 0. enable_i and all inputs are ignored.
- DONE:
  - For an in-range write, update the line.
  - For any in-range access, register data_o with the resulting line. Memory is written in the same edge that raises ack_o.
  - Pulse ack_o=1 for exactly one cycle, then return to IDLE.
- Line index: addr[OB +: log2(DEPTH)], where OB = log2(DATA_W/8).
- Out of range: any nonzero bit above the index field. The request completes normally with ack_o=1 and err_o=1, memory is unchanged, and data_o = 0.
- A write without the strobe feature replaces the whole line.
- enable_i held high across ack: a new request is accepted in the IDLE cycle after the ack cycle. There is no back-to-back acceptance in the ack cycle.
- Reset values: ack_o=0, err_o=0, busy_o=0, data_o=0, state=IDLE, counter=0.
- Memory contents are not reset; benches preload them hierarchically through the array named `memory`.
- Reset mid-request aborts the request. It produces no write and no ack, and the block is in IDLE the cycle after reset deasserts.

## Timing
- Request accepted at edge T; ack_o, err_o and the final data_o are high/valid during the cycle after edge T+LATENCY.
- Throughput: one request per LATENCY+1 cycles.
- busy_o is high from the cycle after edge T up to and including the ack cycle.
- data_o holds its value until the next ack; it is stable between acks.
- err_o is 0 whenever ack_o is 0.

## Configuration
- DATA_MEMORY_LAT_STRB_EN defined: the strb_i port exists, and a write updates only the bytes whose strobe is set. A write with all strobes clear leaves memory unchanged but still acks, and data_o returns the unchanged line.
- DATA_MEMORY_LAT_STRB_EN undefined: the port is absent and writes are full-line.

## Structure
- Package data_memory_lat_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the LATENCY_MIN=1 constant;
  - the byte-merge function (old line, new line, strobes → line).
- Counter width is clog2(LATENCY), and at least 1; it is computed locally in the top module.
- One sub-module: dm_line_ram, a DEPTH×DATA_W array named `memory` with a synchronous write port and a combinational read port. The top module owns the FSM, counter, range check and output registers.

## Test plan
- Preload memory[0]=256'h5, then read addr 0: ack_o rises exactly 10 cycles after accept, data_o=256'h5, err_o=0, busy_o high throughout the wait.
- Write data_i=256'hDEAD_BEEF to addr 32'h40, then read addr 32'h40: memory[2] holds the value, and both requests ack with 11 cycles between accepts.
- Read addr 32'h0001_0000 (out of range for DEPTH=512): ack_o=1, err_o=1, data_o=0, memory unchanged.
- Hold enable_i high continuously with LATENCY=1: acks on every second cycle, with no request accepted during an ack cycle.
- Assert rst_i five cycles into a write to addr 0: no ack, memory[0] keeps its old value, all outputs are 0 after reset.
- With DATA_MEMORY_LAT_STRB_EN, memory[1] all 1s, write 0 with strb_i=32'h0000_000F to addr 32'h20: data_o = all 1s except bytes 0–3 = 0.
